// File: rtl/db_left_ctrl.sv
// db_left_ctrl: sequences the left-neighbour pixel buffer of the deblocking
// filter. STORE streams one LCU's left column (DEPTH words) into a single-port
// RAM; LOAD streams it back through a 2-entry skid FIFO, or streams zeros for
// the first LCU of a row, where no left neighbour exists.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start_i; RAM idle, no stream handshakes
// STORE | accepting DEPTH words, writing each to RAM as it arrives
// LOAD  | issuing reads (or zero fills) and draining the output FIFO
// DONE  | single-cycle completion pulse, then back to IDLE
module db_left_ctrl #(
  parameter int DATA_WIDTH = 128,
  parameter int ADDR_WIDTH = 4,
  parameter int DEPTH      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  mode_i,
  input  logic                  first_i,
  input  logic                  wr_valid_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  output logic                  wr_ready_o,
  output logic                  rd_valid_o,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  input  logic                  rd_ready_i,
  output logic                  rd_last_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  cen_o,
  output logic                  wen_o,
  output logic                  ren_o,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [DATA_WIDTH-1:0] ram_wdata_o,
  input  logic [DATA_WIDTH-1:0] ram_rdata_i
);

  // One extra bit so a count of DEPTH never aliases address 0.
  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] LAST_C  = CW'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_STORE = 2'd1,
    S_LOAD  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                state;
  logic [CW-1:0]         cnt;       // words written (STORE) or reads issued (LOAD)
  logic [CW-1:0]         pop_cnt;   // words consumed by the filter in LOAD
  logic                  zero_q;    // LOAD streams zeros instead of RAM data
  logic                  inflight;  // a read (or zero fill) lands in the FIFO this cycle
  logic [DATA_WIDTH-1:0] fifo0;
  logic [DATA_WIDTH-1:0] fifo1;
  logic                  wr_ptr;
  logic                  rd_ptr;
  logic [1:0]            fifo_cnt;

  logic                  wr_hs;
  logic                  pop;
  logic [2:0]            occ;
  logic                  rd_issue;
  logic                  ram_rd;

  // Handshake decode and read-issue throttle; the slot freed by a same-cycle
  // pop is counted so a continuously ready consumer gets one word per cycle.
  always_comb begin
    wr_hs      = (state == S_STORE) && wr_valid_i;
    rd_valid_o = (state == S_LOAD) && (fifo_cnt != 2'd0);
    pop        = rd_valid_o && rd_ready_i;
    occ        = {1'b0, fifo_cnt} + {2'b00, inflight} - {2'b00, pop};
    rd_issue   = (state == S_LOAD) && (cnt < DEPTH_C) && (occ < 3'd2);
    ram_rd     = rd_issue && !zero_q;
  end

  // RAM port and stream outputs; writes are issued in the handshake cycle.
  always_comb begin
    wr_ready_o  = (state == S_STORE);
    cen_o       = !(wr_hs || ram_rd);
    wen_o       = !wr_hs;
    ren_o       = !((state == S_LOAD) && inflight && !zero_q);
    addr_o      = (wr_hs || ram_rd) ? cnt[ADDR_WIDTH-1:0] : '0;
    ram_wdata_o = wr_hs ? wr_data_i : '0;
    rd_data_o   = rd_valid_o ? (rd_ptr ? fifo1 : fifo0) : '0;
    rd_last_o   = rd_valid_o && (pop_cnt == LAST_C);
    busy_o      = (state != S_IDLE);
    done_o      = (state == S_DONE);
  end

  // Controller FSM with its counters and the 2-entry output FIFO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      pop_cnt  <= '0;
      zero_q   <= 1'b0;
      inflight <= 1'b0;
      fifo0    <= '0;
      fifo1    <= '0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      fifo_cnt <= 2'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_i) begin
            cnt      <= '0;
            pop_cnt  <= '0;
            zero_q   <= first_i;
            inflight <= 1'b0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            fifo_cnt <= 2'd0;
            state    <= mode_i ? S_LOAD : S_STORE;
          end
        end
        S_STORE: begin
          if (wr_hs) begin
            cnt <= cnt + 1'b1;
            if (cnt == LAST_C) state <= S_DONE;
          end
        end
        S_LOAD: begin
          inflight <= rd_issue;
          if (rd_issue) cnt <= cnt + 1'b1;
          // RAM data is only valid in the cycle after the read was issued.
          if (inflight) begin
            if (wr_ptr) fifo1 <= zero_q ? '0 : ram_rdata_i;
            else        fifo0 <= zero_q ? '0 : ram_rdata_i;
            wr_ptr <= ~wr_ptr;
          end
          if (pop) begin
            rd_ptr  <= ~rd_ptr;
            pop_cnt <= pop_cnt + 1'b1;
            if (pop_cnt == LAST_C) state <= S_DONE;
          end
          fifo_cnt <= fifo_cnt + {1'b0, inflight} - {1'b0, pop};
        end
        S_DONE: begin
          inflight <= 1'b0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_db_left_ctrl.sv
// Scoreboard bench for db_left_ctrl: a driver issues STORE/LOAD operations and
// pushes expected RAM writes and stream words into queues; a negedge monitor
// pops and compares whenever the DUT presents a write or a stream handshake.
module tb_db_left_ctrl;
  localparam int DW = 128;
  localparam int AW = 4;
  localparam int D  = 16;

  typedef struct {
    logic [DW-1:0] d;
    logic          l;
  } rd_t;
  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_i, mode_i, first_i;
  logic          wr_valid_i;
  logic [DW-1:0] wr_data_i;
  logic          wr_ready_o;
  logic          rd_valid_o;
  logic [DW-1:0] rd_data_o;
  logic          rd_ready_i;
  logic          rd_last_o, busy_o, done_o;
  logic          cen_o, wen_o, ren_o;
  logic [AW-1:0] addr_o;
  logic [DW-1:0] ram_wdata_o;
  logic [DW-1:0] ram_rdata_i;

  always #5 clk = ~clk;

  db_left_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .mode_i(mode_i), .first_i(first_i),
    .wr_valid_i(wr_valid_i), .wr_data_i(wr_data_i), .wr_ready_o(wr_ready_o),
    .rd_valid_o(rd_valid_o), .rd_data_o(rd_data_o), .rd_ready_i(rd_ready_i),
    .rd_last_o(rd_last_o), .busy_o(busy_o), .done_o(done_o),
    .cen_o(cen_o), .wen_o(wen_o), .ren_o(ren_o), .addr_o(addr_o),
    .ram_wdata_o(ram_wdata_o), .ram_rdata_i(ram_rdata_i)
  );

  int tests = 0;
  int fails = 0;

  // reference model: what the left-pixel buffer should hold after each STORE
  logic [DW-1:0] ref_mem [D];
  // environment RAM, returns garbage whenever no read was issued
  logic [DW-1:0] ram_mem [D];

  rd_t rd_q[$];
  wr_t wr_q[$];

  // monitor state
  int          pops, issues, done_cnt, max_out, cen_low_cnt, outstanding;
  logic [AW:0] exp_rd_addr;
  bit          prev_issue, prev_stall, wr_iss, rd_iss;
  logic [DW-1:0] prev_data;
  rd_t         re;
  wr_t         we;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // single-port RAM model
  always @(posedge clk) begin
    if (!cen_o && !wen_o) ram_mem[addr_o] <= ram_wdata_o;
    if (!cen_o && wen_o) ram_rdata_i <= ram_mem[addr_o];
    else ram_rdata_i <= {$urandom, $urandom, $urandom, $urandom};
  end

  // monitor: compares every RAM access and stream handshake against the queues
  always @(negedge clk) begin
    if (rst) begin
      prev_issue = 1'b0;
      prev_stall = 1'b0;
    end else begin
      wr_iss = !cen_o && !wen_o;
      rd_iss = !cen_o && wen_o;
      if (!cen_o) cen_low_cnt++;
      if (wr_iss) begin
        if (wr_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL wr_unexpected: got write addr %0d expected no write", addr_o);
        end else begin
          we = wr_q.pop_front();
          check("wr_addr", addr_o, we.a);
          check("wr_data", ram_wdata_o, we.d);
        end
      end
      if (rd_iss) begin
        check("rd_addr", addr_o, exp_rd_addr);
        exp_rd_addr++;
        issues++;
      end
      if (prev_issue || !ren_o) check("ren_o", ren_o, !prev_issue);
      if (prev_stall) begin
        check("hold_valid", rd_valid_o, 1'b1);
        check("hold_data", rd_data_o, prev_data);
      end
      if (rd_valid_o && rd_ready_i) begin
        pops++;
        if (rd_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL rd_unexpected: got word %0h expected no word", rd_data_o);
        end else begin
          re = rd_q.pop_front();
          check("rd_data", rd_data_o, re.d);
          check("rd_last", rd_last_o, re.l);
        end
      end
      outstanding = issues - pops;
      if (outstanding > max_out) max_out = outstanding;
      if (done_o) done_cnt++;
      prev_issue = rd_iss;
      prev_stall = rd_valid_o && !rd_ready_i;
      prev_data  = rd_data_o;
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_wr_ready"}, wr_ready_o, 1'b0);
    check({tag, "_rd_valid"}, rd_valid_o, 1'b0);
    check({tag, "_rd_last"}, rd_last_o, 1'b0);
    check({tag, "_rd_data"}, rd_data_o, '0);
    check({tag, "_done"}, done_o, 1'b0);
    check({tag, "_busy"}, busy_o, 1'b0);
    check({tag, "_cen"}, cen_o, 1'b1);
    check({tag, "_wen"}, wen_o, 1'b1);
    check({tag, "_ren"}, ren_o, 1'b1);
    check({tag, "_addr"}, addr_o, '0);
    check({tag, "_wdata"}, ram_wdata_o, '0);
  endtask

  // STORE one LCU; cont holds wr_valid high, pat uses k*0x0101..01 data,
  // abort_at >= 0 asserts rst when that word is due
  task automatic do_store(input bit cont, input bit pat, input int abort_at);
    int k = 0;
    int c = 0;
    int d0;
    logic [7:0] kb;
    @(posedge clk); #1;
    d0 = done_cnt;
    start_i = 1'b1; mode_i = 1'b0; first_i = 1'($urandom % 2);
    @(posedge clk); #1;
    start_i = 1'b0;
    while (k < D && c < 300) begin
      if (k == abort_at) begin
        rst = 1'b1;
        #1;
        check_reset_outputs("abort");
        check("abort_no_pending_wr", wr_q.size(), 0);
        wr_valid_i = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        return;
      end
      wr_valid_i = cont ? 1'b1 : 1'($urandom % 2);
      kb = 8'(k);
      wr_data_i = pat ? {16{kb}} : {$urandom, $urandom, $urandom, $urandom};
      if (wr_valid_i && wr_ready_o) begin
        wr_q.push_back('{a: AW'(k), d: wr_data_i});
        ref_mem[k] = wr_data_i;
        k++;
      end
      @(posedge clk); #1;
      c++;
    end
    wr_valid_i = 1'b0;
    check("store_words", k, D);
    if (cont) check("store_cycles", c, D);
    check("store_done", done_o, 1'b1);
    check("store_busy_done", busy_o, 1'b1);
    @(posedge clk); #1;
    check("store_done_pulse", done_o, 1'b0);
    check("store_done_count", done_cnt - d0, 1);
    check("store_wr_q_empty", wr_q.size(), 0);
  endtask

  // LOAD one LCU; zero = first LCU of a row, rnd = random rd_ready,
  // poke = random start_i pulses during the operation, timing = latency checks
  task automatic do_load(input bit zero, input bit rnd, input bit poke, input bit timing);
    int c = 0;
    int first_v = -1;
    int last_v = -1;
    int nv = 0;
    int d0;
    for (int k = 0; k < D; k++)
      rd_q.push_back('{d: zero ? '0 : ref_mem[k], l: (k == D - 1)});
    @(posedge clk); #1;
    d0 = done_cnt;
    exp_rd_addr = '0; issues = 0; pops = 0; max_out = 0; cen_low_cnt = 0;
    start_i = 1'b1; mode_i = 1'b1; first_i = zero;
    @(posedge clk); #1;
    start_i = 1'b0;
    while (!done_o && c < 300) begin
      if (rd_valid_o) begin
        if (first_v < 0) first_v = c;
        last_v = c;
        nv++;
      end
      rd_ready_i = rnd ? 1'($urandom % 2) : 1'b1;
      start_i = poke && ($urandom % 4 == 0);
      mode_i = 1'($urandom % 2);
      @(posedge clk); #1;
      c++;
    end
    start_i = 1'b0;
    rd_ready_i = 1'b0;
    check("load_done", done_o, 1'b1);
    check("load_words", pops, D);
    check("load_rd_q_empty", rd_q.size(), 0);
    if (zero) check("zero_cen_held", cen_low_cnt, 0);
    else check("load_outstanding_le2", (max_out <= 2), 1'b1);
    if (timing) begin
      check("first_valid_latency", first_v, 2);
      check("valid_span", last_v - first_v + 1, D);
      check("valid_cycles", nv, D);
    end
    @(posedge clk); #1;
    check("load_done_pulse", done_o, 1'b0);
    check("load_idle_busy", busy_o, 1'b0);
    check("load_done_count", done_cnt - d0, 1);
  endtask

  initial begin
    rst = 1'b1;
    start_i = 1'b0; mode_i = 1'b0; first_i = 1'b0;
    wr_valid_i = 1'b0; wr_data_i = '0; rd_ready_i = 1'b0;
    pops = 0; issues = 0; done_cnt = 0; max_out = 0; cen_low_cnt = 0;
    exp_rd_addr = '0; prev_issue = 1'b0; prev_stall = 1'b0; prev_data = '0;
    for (int i = 0; i < D; i++) begin
      ref_mem[i] = '0;
      ram_mem[i] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;

    do_store(1'b1, 1'b1, -1);          // continuous pattern store
    do_load(1'b0, 1'b0, 1'b0, 1'b1);   // full-rate load with latency checks
    do_load(1'b0, 1'b1, 1'b0, 1'b0);   // backpressured load
    do_load(1'b1, 1'b1, 1'b0, 1'b0);   // first LCU: zeros, no RAM
    do_load(1'b1, 1'b0, 1'b0, 1'b1);   // zeros at full rate
    do_store(1'b0, 1'b0, -1);          // bursty random store
    do_load(1'b0, 1'b1, 1'b1, 1'b0);   // start_i pokes during load
    do_store(1'b1, 1'b1, 7);           // reset at word 7
    do_store(1'b1, 1'b1, -1);
    do_load(1'b0, 1'b0, 1'b0, 1'b1);
    repeat (3) begin
      do_store(1'b0, 1'b0, -1);
      do_load(1'b0, 1'b1, 1'b1, 1'b0);
    end

    check("final_wr_q_empty", wr_q.size(), 0);
    check("final_rd_q_empty", rd_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
